// File: rtl/z_test_requester_if.sv
// z_test_requester_if
//   Fragment-in, memory-request, and result bundle for the depth-test requester.
//   master : requester side (accepts fragments, issues memory requests, reports results)
//   slave  : environment side (supplies fragments, serves memory, consumes results)
//   Signals:
//     frag_valid/frag_ready/frag_address/frag_depth : fragment handshake
//     mem_enable/mem_RW/mem_address/mem_pix_out     : memory request (RW 0=read, 1=write)
//     mem_pix_in/mem_ack_in                         : memory response
//     done/written/error                            : per-fragment completion report
interface z_test_requester_if #(
  parameter int MEM_LENGTH = 8,
  parameter int PIX_WIDTH  = 16
);
  logic                  frag_valid;
  logic                  frag_ready;
  logic [MEM_LENGTH-1:0] frag_address;
  logic [PIX_WIDTH-1:0]  frag_depth;

  logic                  mem_enable;
  logic                  mem_RW;
  logic [MEM_LENGTH-1:0] mem_address;
  logic [PIX_WIDTH-1:0]  mem_pix_out;
  logic [PIX_WIDTH-1:0]  mem_pix_in;
  logic                  mem_ack_in;

  logic                  done;
  logic                  written;
  logic                  error;

  modport master (
    input  frag_valid, frag_address, frag_depth, mem_pix_in, mem_ack_in,
    output frag_ready, mem_enable, mem_RW, mem_address, mem_pix_out,
           done, written, error
  );

  modport slave (
    output frag_valid, frag_address, frag_depth, mem_pix_in, mem_ack_in,
    input  frag_ready, mem_enable, mem_RW, mem_address, mem_pix_out,
           done, written, error
  );
endinterface

// File: rtl/z_test_requester.sv
// z_test_requester
//   Accepts one fragment at a time, reads the stored depth at its address,
//   and writes the fragment depth back only when it is strictly closer.
//   Every request is bounded by a timeout; a timed-out fragment reports error.
//   Ports:
//     clk_i    : clock, all state changes on rising edge
//     reset_i  : synchronous active-low reset
//     bus_io   : z_test_requester_if.master (fragment, memory and result signals)
//
//   state  | meaning
//   IDLE   | ready for a fragment; latch address/depth on frag_valid
//   RD_REQ | read request active, waiting for a qualified ack
//   CMP    | one idle cycle, compare fragment depth with stored depth
//   WR_REQ | write request active, waiting for a qualified ack
//   DONE   | one-cycle done pulse carrying written/error
module z_test_requester #(
  parameter int MEM_LENGTH = 8,
  parameter int PIX_WIDTH  = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  z_test_requester_if.master bus_io
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, CMP, WR_REQ, DONE} state_e;

  state_e                state_q, state_d;
  logic [MEM_LENGTH-1:0] addr_q, addr_d;
  logic [PIX_WIDTH-1:0]  depth_q, depth_d;
  logic [PIX_WIDTH-1:0]  rd_pix_q, rd_pix_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  written_q, written_d;
  logic                  error_q, error_d;

  logic ack_ok;
  logic timeout_hit;

  // cnt_q counts completed cycles of the current request, so a zero count
  // marks the first cycle, whose ack may be left over from a previous access.
  assign ack_ok      = bus_io.mem_ack_in && (cnt_q != '0);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      depth_q   <= '0;
      rd_pix_q  <= '0;
      cnt_q     <= '0;
      written_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      depth_q   <= depth_d;
      rd_pix_q  <= rd_pix_d;
      cnt_q     <= cnt_d;
      written_q <= written_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    depth_d   = depth_q;
    rd_pix_d  = rd_pix_q;
    cnt_d     = cnt_q;
    written_d = written_q;
    error_d   = error_q;

    bus_io.frag_ready  = 1'b0;
    bus_io.mem_enable  = 1'b0;
    bus_io.mem_RW      = 1'b0;
    bus_io.mem_address = '0;
    bus_io.mem_pix_out = '0;
    bus_io.done        = 1'b0;
    bus_io.written     = 1'b0;
    bus_io.error       = 1'b0;

    case (state_q)
      IDLE: begin
        bus_io.frag_ready = 1'b1;
        written_d = 1'b0;
        error_d   = 1'b0;
        if (bus_io.frag_valid) begin
          addr_d  = bus_io.frag_address;
          depth_d = bus_io.frag_depth;
          cnt_d   = '0;
          state_d = RD_REQ;
        end
      end

      RD_REQ: begin
        bus_io.mem_enable  = 1'b1;
        bus_io.mem_address = addr_q;
        cnt_d = cnt_q + CNT_W'(1);
        // A qualified ack on the timeout cycle still wins.
        if (ack_ok) begin
          rd_pix_d = bus_io.mem_pix_in;
          state_d  = CMP;
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = DONE;
        end
      end

      CMP: begin
        if (depth_q < rd_pix_q) begin
          cnt_d   = '0;
          state_d = WR_REQ;
        end else begin
          state_d = DONE;
        end
      end

      WR_REQ: begin
        bus_io.mem_enable  = 1'b1;
        bus_io.mem_RW      = 1'b1;
        bus_io.mem_address = addr_q;
        bus_io.mem_pix_out = depth_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (ack_ok) begin
          written_d = 1'b1;
          state_d   = DONE;
        end else if (timeout_hit) begin
          error_d = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        bus_io.done    = 1'b1;
        bus_io.written = written_q;
        bus_io.error   = error_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/z_test_requester.md
Z_TEST_REQUESTER -- requirements
Module: z_test_requester

Interface
REQ-001 Parameter MEM_LENGTH, default 8, SHALL set the address width in bits.
REQ-002 Parameter PIX_WIDTH, default 16, SHALL set the depth/pixel data width in bits.
REQ-003 Parameter TIMEOUT, default 16, SHALL set the maximum cycles a request waits for ack.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-low reset.
REQ-006 Port frag_valid, input, 1: upstream fragment available.
REQ-007 Port frag_ready, output, 1: block accepts a fragment this cycle.
REQ-008 Port frag_address, input, MEM_LENGTH: depth-buffer address of the fragment.
REQ-009 Port frag_depth, input, PIX_WIDTH: fragment depth (unsigned; smaller is closer).
REQ-010 Port mem_enable, output, 1: memory request active.
REQ-011 Port mem_RW, output, 1: 0 = read, 1 = write.
REQ-012 Port mem_address, output, MEM_LENGTH: request address.
REQ-013 Port mem_pix_out, output, PIX_WIDTH: write data to memory.
REQ-014 Port mem_pix_in, input, PIX_WIDTH: read data from memory.
REQ-015 Port mem_ack_in, input, 1: memory acknowledge.
REQ-016 Port done, output, 1: one-cycle pulse marking that a fragment has finished.
REQ-017 Port written, output, 1: valid with done; 1 = depth was updated.
REQ-018 Port error, output, 1: valid with done; 1 = request timed out.

Function
REQ-019 FSM states SHALL be IDLE, RD_REQ, CMP, WR_REQ, DONE.
REQ-020 IDLE: frag_ready=1 only here; frag_valid high at an edge latches frag_address/frag_depth -> RD_REQ.
REQ-021 RD_REQ: mem_enable=1, mem_RW=0, mem_address=latched address; ack -> capture mem_pix_in, go to CMP.
REQ-022 mem_ack_in SHALL be qualified only from the second consecutive cycle of mem_enable high; a first-cycle ack (stale) is ignored.
REQ-023 CMP: mem_enable=0 for exactly one cycle; latched depth strictly less than captured depth -> WR_REQ, else (greater or equal) -> DONE with written=0.
REQ-024 WR_REQ: mem_enable=1, mem_RW=1, mem_address=latched address, mem_pix_out=latched depth; qualified ack -> DONE with written=1.
REQ-025 mem_address, mem_RW, mem_pix_out SHALL remain stable for the whole time mem_enable is high.
REQ-026 DONE: done=1, mem_enable=0 for one cycle, then IDLE; written/error valid only while done=1, else 0.
REQ-027 Timeout counter SHALL clear on entering RD_REQ/WR_REQ and increment each request cycle; reaching TIMEOUT cycles without a qualified ack -> DONE with error=1, written=0.
REQ-028 An ack arriving in the same cycle the timeout is reached SHALL take priority (no error).
REQ-029 Latency from accept edge (edge 0), ack in the second request cycle: done high in cycle 4 (no write), cycle 6 (write).
REQ-030 mem_enable SHALL be low for at least one cycle between any two requests.
REQ-031 mem_pix_out SHALL be 0 whenever mem_RW=0 or mem_enable=0.

Reset
REQ-032 reset low at an edge SHALL force IDLE and set mem_enable, mem_RW, mem_address, mem_pix_out, done, written, error, timeout counter and latched data to 0; frag_ready=1 after release.
REQ-033 Reset mid-request SHALL drop mem_enable at that same edge; the in-flight fragment is discarded with no done pulse.

Verification
REQ-034 Fragment addr=0x05, depth=0x0100; memory returns 0x0200 -> read then write of 0x0100 to 0x05, done cycle 6, written=1, error=0.
REQ-035 Depth 0x0300 vs stored 0x0200, and equal case 0x0200 vs 0x0200 -> read only, no write request, done cycle 4, written=0.
REQ-036 Memory never acks, TIMEOUT=16 -> mem_enable high exactly 16 cycles, then done=1, error=1, written=0, mem_enable=0.
REQ-037 Stale ack held high during the first WR_REQ cycle, no ack afterwards -> ack ignored, request remains active until timeout -> error=1.
REQ-038 reset low during RD_REQ -> mem_enable=0 immediately after the edge, no done, frag_ready=1 after release; next fragment processes normally.
REQ-039 Back-to-back frag_valid held high -> second fragment accepted only in IDLE after done, mem_enable gap of at least 1 cycle.
